// File: rtl/watchdog_pkg.sv
// Shared types for the commit watchdog: FSM states, end causes and the boot PC.
package watchdog_pkg;

    typedef enum logic [1:0] {
        ST_RUN   = 2'd0,
        ST_DRAIN = 2'd1,
        ST_DONE  = 2'd2
    } state_e;

    typedef enum logic [2:0] {
        CAUSE_NONE    = 3'd0,
        CAUSE_HALT    = 3'd1,
        CAUSE_TIMEOUT = 3'd2,
        CAUSE_STALL   = 3'd3,
        CAUSE_LOOP    = 3'd4,
        CAUSE_ERROR   = 3'd5
    } cause_e;

    localparam logic [31:0] RESET_PC = 32'h0000_0060;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter adding a variable amount per cycle, with synchronous clear.
// Sticks at all-ones instead of wrapping.
module sat_counter #(
    parameter int W     = 32,
    parameter int AMT_W = 1
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             i_clr,
    input  logic [AMT_W-1:0] i_amt,
    output logic [W-1:0]     o_cnt
);

    logic [W-1:0] r_cnt;
    logic [W:0]   w_sum;

    // One extra bit catches the carry out that signals saturation.
    assign w_sum = {1'b0, r_cnt} + (W+1)'(i_amt);

    always_ff @(posedge clk) begin
        if (rst || i_clr) begin
            r_cnt <= '0;
        end else if (w_sum[W]) begin
            r_cnt <= '1;
        end else begin
            r_cnt <= w_sum[W-1:0];
        end
    end

    assign o_cnt = r_cnt;

endmodule

// File: rtl/commit_watchdog.sv
// Ends a simulation run on halt, timeout, commit stall, same-PC loop or checker error.
// End conditions are sampled in RUN and register one cycle later; errors drain DRAIN_CYC cycles first.
module commit_watchdog
    import watchdog_pkg::*;
#(
    parameter int NUM_CH    = 2,
    parameter int CNT_W     = 32,
    parameter int LOOP_W    = 11,
    parameter int DRAIN_CYC = 5
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic [NUM_CH-1:0]      commit,
    input  logic [NUM_CH-1:0][31:0] pc_rdata,
    input  logic [NUM_CH-1:0]      halt,
    input  logic [15:0]            errcode,
    input  logic [CNT_W-1:0]       timeout_lim,
    input  logic [CNT_W-1:0]       stall_lim,
    input  logic                   loop_en,
    output logic                   finish,
    output logic                   done,
    output logic [2:0]             cause,
    output logic [15:0]            err_latched,
    output logic [CNT_W-1:0]       cycles,
    output logic [CNT_W-1:0]       retired
);

    localparam int PC_W = $clog2(NUM_CH + 1);
    localparam int DR_W = $clog2(DRAIN_CYC + 1);

    state_e              r_state, w_state_nxt;
    cause_e              r_cause, w_cause_nxt;
    logic [DR_W-1:0]     r_drain, w_drain_nxt;
    logic [15:0]         r_err, w_err_nxt;
    logic                r_finish;
    logic [LOOP_W-1:0]   r_rep, w_rep_nxt;
    logic [31:0]         r_last_pc, w_pc_nxt;
    logic [CNT_W-1:0]    w_idle;
    logic [PC_W-1:0]     w_ncommit;
    logic                w_active, w_run;
    logic                w_halt, w_timeout, w_stall, w_loop, w_error;

    assign w_active = (r_state != ST_DONE);
    assign w_run    = (r_state == ST_RUN);

    always_comb begin
        w_ncommit = '0;
        for (int i = 0; i < NUM_CH; i++) begin
            w_ncommit = w_ncommit + PC_W'(commit[i]);
        end
    end

    sat_counter #(.W(CNT_W), .AMT_W(1)) u_cycles (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_amt (w_active),
        .o_cnt (cycles)
    );

    sat_counter #(.W(CNT_W), .AMT_W(PC_W)) u_retired (
        .clk   (clk),
        .rst   (rst),
        .i_clr (1'b0),
        .i_amt (w_active ? w_ncommit : '0),
        .o_cnt (retired)
    );

    sat_counter #(.W(CNT_W), .AMT_W(1)) u_idle (
        .clk   (clk),
        .rst   (rst),
        .i_clr (|commit),
        .i_amt (w_run && (commit == '0)),
        .o_cnt (w_idle)
    );

    // Oldest channel first, so a repeat can be seen both across and within a cycle.
    always_comb begin
        w_pc_nxt  = r_last_pc;
        w_rep_nxt = r_rep;
        for (int i = 0; i < NUM_CH; i++) begin
            if (commit[i]) begin
                if (pc_rdata[i] == w_pc_nxt) begin
                    if (w_rep_nxt != '1) begin
                        w_rep_nxt = w_rep_nxt + LOOP_W'(1);
                    end
                end else begin
                    w_rep_nxt = '0;
                end
                w_pc_nxt = pc_rdata[i];
            end
        end
    end

    assign w_halt    = |(commit & halt);
    assign w_timeout = (timeout_lim != '0) && (cycles >= timeout_lim);
    assign w_stall   = (stall_lim != '0) && (w_idle >= stall_lim);
    assign w_loop    = loop_en && (w_rep_nxt == '1);
    assign w_error   = (errcode != 16'd0);

    always_comb begin
        w_state_nxt = r_state;
        w_cause_nxt = r_cause;
        w_drain_nxt = r_drain;
        w_err_nxt   = r_err;
        unique case (r_state)
            ST_RUN: begin
                if (w_error) begin
                    w_state_nxt = ST_DRAIN;
                    w_drain_nxt = DR_W'(DRAIN_CYC);
                    w_err_nxt   = errcode;
                end else if (w_halt) begin
                    w_state_nxt = ST_DONE;
                    w_cause_nxt = CAUSE_HALT;
                end else if (w_loop) begin
                    w_state_nxt = ST_DONE;
                    w_cause_nxt = CAUSE_LOOP;
                end else if (w_stall) begin
                    w_state_nxt = ST_DONE;
                    w_cause_nxt = CAUSE_STALL;
                end else if (w_timeout) begin
                    w_state_nxt = ST_DONE;
                    w_cause_nxt = CAUSE_TIMEOUT;
                end
            end
            ST_DRAIN: begin
                w_drain_nxt = r_drain - DR_W'(1);
                if (r_drain == DR_W'(1)) begin
                    w_state_nxt = ST_DONE;
                    w_cause_nxt = CAUSE_ERROR;
                end
            end
            ST_DONE: begin
                w_state_nxt = ST_DONE;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state   <= ST_RUN;
            r_cause   <= CAUSE_NONE;
            r_drain   <= '0;
            r_err     <= '0;
            r_finish  <= 1'b0;
            r_rep     <= '0;
            r_last_pc <= RESET_PC;
        end else begin
            r_state  <= w_state_nxt;
            r_cause  <= w_cause_nxt;
            r_drain  <= w_drain_nxt;
            r_err    <= w_err_nxt;
            r_finish <= w_active && (w_state_nxt == ST_DONE);
            if (w_run) begin
                r_rep     <= w_rep_nxt;
                r_last_pc <= w_pc_nxt;
            end
        end
    end

    assign finish      = r_finish;
    assign done        = (r_state == ST_DONE);
    assign cause       = r_cause;
    assign err_latched = r_err;

endmodule

// File: tb/tb_commit_watchdog.sv
// Bench for commit_watchdog: vector table, directed corner sequences and random runs vs a reference model.
module tb_commit_watchdog;

    localparam int NUM_CH    = 2;
    localparam int CNT_W     = 32;
    localparam int LOOP_W    = 4;
    localparam int DRAIN_CYC = 5;
    localparam longint unsigned CMAX = 64'hFFFF_FFFF;
    localparam int REPMAX = (1 << LOOP_W) - 1;

    logic                    clk = 1'b0;
    logic                    rst = 1'b1;
    logic [NUM_CH-1:0]       commit = '0;
    logic [NUM_CH-1:0][31:0] pc_rdata = '0;
    logic [NUM_CH-1:0]       halt = '0;
    logic [15:0]             errcode = '0;
    logic [CNT_W-1:0]        timeout_lim = '0;
    logic [CNT_W-1:0]        stall_lim = '0;
    logic                    loop_en = 1'b0;
    logic                    finish, done;
    logic [2:0]              cause;
    logic [15:0]             err_latched;
    logic [CNT_W-1:0]        cycles, retired;

    commit_watchdog #(
        .NUM_CH(NUM_CH), .CNT_W(CNT_W), .LOOP_W(LOOP_W), .DRAIN_CYC(DRAIN_CYC)
    ) dut (
        .clk(clk), .rst(rst), .commit(commit), .pc_rdata(pc_rdata), .halt(halt),
        .errcode(errcode), .timeout_lim(timeout_lim), .stall_lim(stall_lim),
        .loop_en(loop_en), .finish(finish), .done(done), .cause(cause),
        .err_latched(err_latched), .cycles(cycles), .retired(retired)
    );

    always #5 clk = ~clk;

    int n_tests = 0;
    int n_fail  = 0;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_tests++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference model: phase 0 = running, 1 = draining after an error, 2 = finished.
    int               m_phase;
    longint unsigned  m_cycles, m_retired, m_idle;
    int               m_rep;
    logic [31:0]      m_prev;
    int               m_drain;
    int               m_cause;
    logic [15:0]      m_err;
    bit               m_finish;

    function automatic longint unsigned sat_add(longint unsigned a, longint unsigned b);
        return (a + b > CMAX) ? CMAX : a + b;
    endfunction

    task automatic model_step();
        bit c_halt, c_to, c_st, c_lp;
        int rep;
        logic [31:0] prev;
        if (rst) begin
            m_phase = 0; m_cycles = 0; m_retired = 0; m_idle = 0;
            m_rep = 0; m_prev = 32'h60; m_drain = 0; m_cause = 0;
            m_err = 0; m_finish = 0;
        end else begin
            m_finish = 0;
            if (m_phase != 2) begin
                if (m_phase == 0) begin
                    c_halt = (commit & halt) != 0;
                    c_to   = (timeout_lim != 0) && (m_cycles >= timeout_lim);
                    c_st   = (stall_lim != 0) && (m_idle >= stall_lim);
                    rep = m_rep;
                    prev = m_prev;
                    for (int i = 0; i < NUM_CH; i++) begin
                        if (commit[i]) begin
                            rep  = (pc_rdata[i] == prev) ? ((rep < REPMAX) ? rep + 1 : REPMAX) : 0;
                            prev = pc_rdata[i];
                        end
                    end
                    c_lp = loop_en && (rep == REPMAX);
                    m_rep = rep;
                    m_prev = prev;
                    m_idle = (commit != 0) ? 0 : sat_add(m_idle, 1);
                    if (errcode != 0) begin
                        m_phase = 1; m_drain = DRAIN_CYC; m_err = errcode;
                    end else if (c_halt || c_lp || c_st || c_to) begin
                        m_phase = 2; m_finish = 1;
                        m_cause = c_halt ? 1 : c_lp ? 4 : c_st ? 3 : 2;
                    end
                end else if (m_drain == 1) begin
                    m_phase = 2; m_finish = 1; m_cause = 5;
                end else begin
                    m_drain--;
                end
                m_cycles  = sat_add(m_cycles, 1);
                m_retired = sat_add(m_retired, $countones(commit));
            end
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
        chk("finish", finish, m_finish);
        chk("done", done, m_phase == 2);
        chk("cause", cause, (m_phase == 2) ? m_cause : 0);
        chk("err_latched", err_latched, m_err);
        chk("cycles", cycles, m_cycles);
        chk("retired", retired, m_retired);
    endtask

    task automatic set_idle();
        commit = '0; halt = '0; errcode = '0; pc_rdata = '0;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        tick();
        tick();
        rst = 1'b0;
    endtask

    typedef struct {
        logic [1:0]  commit;
        logic [1:0]  halt;
        logic [15:0] err;
        logic [31:0] pc0, pc1;
        logic [31:0] tlim, slim;
        logic        loop_en;
        int          exp_cause;
        int          exp_fin;   // cycle (from reset release) in which finish is high; -1 = never
    } vec_t;

    vec_t vt[11];

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "time limit");
    end

    initial begin
        int fin, npulse;
        bit quiet;

        vt[0]  = '{2'b11, 2'b10, 16'd0, 32'h100, 32'h100, 32'd0,  32'd0, 1'b0, 1, 1};
        vt[1]  = '{2'b00, 2'b11, 16'd0, 32'h100, 32'h100, 32'd0,  32'd4, 1'b0, 3, 5};
        vt[2]  = '{2'b00, 2'b00, 16'd0, 32'h100, 32'h100, 32'd10, 32'd0, 1'b0, 2, 11};
        vt[3]  = '{2'b00, 2'b00, 16'd0, 32'h100, 32'h100, 32'd6,  32'd6, 1'b0, 3, 7};
        vt[4]  = '{2'b01, 2'b00, 16'd0, 32'h100, 32'h100, 32'd15, 32'd0, 1'b1, 4, 16};
        vt[5]  = '{2'b11, 2'b00, 16'd0, 32'h100, 32'h100, 32'd0,  32'd0, 1'b1, 4, 8};
        vt[6]  = '{2'b11, 2'b00, 16'd0, 32'h100, 32'h100, 32'd20, 32'd0, 1'b0, 2, 21};
        vt[7]  = '{2'b11, 2'b00, 16'd0, 32'h100, 32'h104, 32'd12, 32'd0, 1'b1, 2, 13};
        vt[8]  = '{2'b11, 2'b11, 16'd3, 32'h100, 32'h100, 32'd0,  32'd0, 1'b0, 5, 6};
        vt[9]  = '{2'b00, 2'b00, 16'd1, 32'h100, 32'h100, 32'd3,  32'd0, 1'b0, 5, 6};
        vt[10] = '{2'b01, 2'b00, 16'd0, 32'h100, 32'h100, 32'd0,  32'd0, 1'b0, 0, -1};

        // Reset state
        set_idle();
        do_reset();
        chk("rst_done", done, 0);
        chk("rst_cycles", cycles, 0);
        chk("rst_last_pc", dut.r_last_pc, 32'h60);

        // Vector table: constant inputs from reset until finish (or 200 cycles)
        for (int v = 0; v < 11; v++) begin
            timeout_lim = vt[v].tlim; stall_lim = vt[v].slim; loop_en = vt[v].loop_en;
            set_idle();
            do_reset();
            commit = vt[v].commit; halt = vt[v].halt; errcode = vt[v].err;
            pc_rdata[0] = vt[v].pc0; pc_rdata[1] = vt[v].pc1;
            fin = -1;
            for (int i = 0; i < 200 && fin < 0; i++) begin
                tick();
                if (finish === 1'b1) fin = i + 1;
            end
            chk($sformatf("vec%0d_fin", v), fin, vt[v].exp_fin);
            chk($sformatf("vec%0d_cause", v), cause, vt[v].exp_cause);
        end

        // Two channels commit for 10 cycles, then a halt on ch1
        timeout_lim = 0; stall_lim = 0; loop_en = 0;
        set_idle();
        do_reset();
        fin = -1; npulse = 0;
        for (int i = 0; i < 16; i++) begin
            commit = 2'b11;
            halt = (i == 10) ? 2'b10 : 2'b00;
            pc_rdata[0] = 32'(i * 8); pc_rdata[1] = 32'(i * 8 + 4);
            tick();
            if (finish === 1'b1) begin
                npulse++;
                if (fin < 0) fin = i + 1;
            end
        end
        chk("halt_fin", fin, 11);
        chk("halt_pulses", npulse, 1);
        chk("halt_cause", cause, 1);
        chk("halt_retired", retired, 22);

        // Timeout at 100, then disabled timeout runs 1000 cycles
        timeout_lim = 100;
        set_idle();
        do_reset();
        fin = -1;
        for (int i = 0; i < 300 && fin < 0; i++) begin
            tick();
            if (finish === 1'b1) fin = i + 1;
        end
        chk("tmo_fin", fin, 101);
        chk("tmo_cause", cause, 2);
        chk("tmo_cycles", cycles, 101);
        timeout_lim = 0;
        do_reset();
        npulse = 0;
        for (int i = 0; i < 1000; i++) begin
            tick();
            if (finish === 1'b1) npulse++;
        end
        chk("tmo_off_pulses", npulse, 0);
        chk("tmo_off_cycles", cycles, 1000);

        // Stall: 7-cycle gap is tolerated, an 8-cycle gap is not
        stall_lim = 8;
        set_idle();
        do_reset();
        fin = -1;
        for (int i = 0; i < 40 && fin < 0; i++) begin
            commit = (i < 3 || i == 10) ? 2'b01 : 2'b00;
            pc_rdata[0] = 32'(i * 4);
            tick();
            if (finish === 1'b1) fin = i + 1;
        end
        chk("stall_fin", fin, 20);
        chk("stall_cause", cause, 3);
        stall_lim = 0;

        // Error at 10, halt at 12, second error at 13
        set_idle();
        do_reset();
        fin = -1; npulse = 0;
        for (int i = 0; i < 30; i++) begin
            commit = 2'b01;
            pc_rdata[0] = 32'(i * 4);
            halt = (i == 12) ? 2'b01 : 2'b00;
            errcode = (i == 10) ? 16'd3 : (i == 13) ? 16'd7 : 16'd0;
            tick();
            if (finish === 1'b1) begin
                npulse++;
                if (fin < 0) fin = i + 1;
            end
        end
        chk("err_fin", fin, 16);
        chk("err_pulses", npulse, 1);
        chk("err_cause", cause, 5);
        chk("err_latched_first", err_latched, 3);

        // Halt with error goes to drain; reset during drain cancels the run
        set_idle();
        do_reset();
        commit = 2'b11; halt = 2'b01; errcode = 16'd5;
        pc_rdata[0] = 32'h200; pc_rdata[1] = 32'h200;
        tick();
        chk("he_no_done", done, 0);
        chk("he_err", err_latched, 5);
        set_idle();
        tick();
        tick();
        rst = 1'b1; commit = 2'b11; halt = 2'b11; errcode = 16'd9;
        tick();
        chk("drain_rst_finish", finish, 0);
        chk("drain_rst_err", err_latched, 0);
        chk("drain_rst_retired", retired, 0);
        chk("drain_rst_last_pc", dut.r_last_pc, 32'h60);
        rst = 1'b0;
        set_idle();
        npulse = 0;
        for (int i = 0; i < 20; i++) begin
            tick();
            if (finish === 1'b1) npulse++;
        end
        chk("drain_rst_pulses", npulse, 0);

        // Random runs against the model
        for (int r = 0; r < 25; r++) begin
            timeout_lim = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(20, 200));
            stall_lim   = ($urandom_range(0, 2) == 0) ? 32'd0 : 32'($urandom_range(2, 12));
            loop_en     = 1'($urandom_range(0, 1));
            quiet       = ($urandom_range(0, 2) == 0);
            set_idle();
            do_reset();
            for (int i = 0; i < 250; i++) begin
                if (quiet ? ($urandom_range(0, 3) != 0) : ($urandom_range(0, 5) == 0))
                    commit = 2'b00;
                else
                    commit = 2'($urandom_range(1, 3));
                halt = ($urandom_range(0, 59) == 0) ? 2'($urandom_range(1, 3)) : 2'b00;
                errcode = ($urandom_range(0, 99) == 0) ? 16'($urandom_range(1, 65535)) : 16'd0;
                pc_rdata[0] = ($urandom_range(0, 7) == 0) ? 32'h104 : 32'h100;
                pc_rdata[1] = ($urandom_range(0, 7) == 0) ? 32'h104 : 32'h100;
                rst = ($urandom_range(0, 199) == 0);
                tick();
            end
            rst = 1'b0;
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/commit_watchdog.md
COMMIT_WATCHDOG -- requirements
Module: commit_watchdog

Interface
REQ-001 NUM_CH, 2, commit channels per cycle (1..4).
REQ-002 CNT_W, 32, width of the cycle, retire, idle and limit counters.
REQ-003 LOOP_W, 11, width of the same-PC repeat counter.
REQ-004 DRAIN_CYC, 5, cycles from error detection to finish (>=1).
REQ-005 clk  input  1  clock; all state on posedge.
REQ-006 rst  input  1  synchronous, active-high reset.
REQ-007 commit  input  NUM_CH  per-channel commit valid; channel i is older than i+1.
REQ-008 pc_rdata  input  NUM_CH x 32  PC of each committing instruction.
REQ-009 halt  input  NUM_CH  per-channel halt flag, qualified by commit.
REQ-010 errcode  input  16  checker error code; nonzero means error.
REQ-011 timeout_lim  input  CNT_W  total-cycle budget; 0 disables.
REQ-012 stall_lim  input  CNT_W  maximum consecutive no-commit cycles; 0 disables.
REQ-013 loop_en  input  1  enables same-PC loop detection.
REQ-014 finish  output  1  one-cycle pulse when the run ends.
REQ-015 done  output  1  level, high from finish until reset.
REQ-016 cause  output  3  end cause; valid while done.
REQ-017 err_latched  output  16  first nonzero errcode captured.
REQ-018 cycles  output  CNT_W  RUN/DRAIN cycles since reset release.
REQ-019 retired  output  CNT_W  total committed instructions.

Function
REQ-020 FSM states: RUN, DRAIN, DONE; RUN after reset; DONE is absorbing until reset.
REQ-021 cause encoding: 0 NONE, 1 HALT, 2 TIMEOUT, 3 STALL, 4 LOOP, 5 ERROR.
REQ-022 In RUN and DRAIN: cycles += 1 and retired += popcount(commit) every cycle; both saturate at all-ones; both frozen in DONE.
REQ-023 End conditions are evaluated combinationally in RUN in cycle t; done, finish and cause register at t+1.
REQ-024 HALT: any channel with commit & halt.
REQ-025 TIMEOUT: timeout_lim != 0 and cycles >= timeout_lim.
REQ-026 STALL: idle counter increments on RUN cycles with commit == 0, clears on any commit, saturates; condition: stall_lim != 0 and idle >= stall_lim.
REQ-027 LOOP: walk committing channels oldest first; rep += 1 (saturating) if the channel's PC equals the running previous PC, else rep = 0; the previous PC becomes that channel's PC; the final previous PC registers into last_pc; no-commit cycles hold both; condition: loop_en and rep == 2^LOOP_W-1.
REQ-028 ERROR: errcode != 0 in RUN captures err_latched and enters DRAIN with the drain counter set to DRAIN_CYC.
REQ-029 DRAIN decrements the drain counter each cycle; when it reaches 1, the next state is DONE with cause ERROR; finish rises exactly DRAIN_CYC+1 cycles after detection.
REQ-030 Simultaneous conditions resolve by priority ERROR > HALT > LOOP > STALL > TIMEOUT.
REQ-031 In DRAIN and DONE, all other conditions and errcode are ignored; err_latched never overwrites.
REQ-032 finish is high for exactly one cycle per run; done stays high.

Reset
REQ-033 rst in any state, including DRAIN, forces on the next edge: state RUN; cycles, retired, idle, rep, drain counter, finish, done, cause and err_latched to 0; last_pc to 32'h00000060.
REQ-034 rst overrides every end condition in the same cycle; no finish is generated.

Structure
REQ-035 Package watchdog_pkg holds the state enum, the cause enum and RESET_PC = 32'h00000060.
REQ-036 Sub-module sat_counter: parametrised width, synchronous clear, saturating add of a variable amount; instantiated for cycles, retired and idle.

Verification
REQ-037 NUM_CH=2, both channels commit for 10 cycles, then commit with halt on ch1 -> one finish pulse, cause=1, retired=22.
REQ-038 timeout_lim=100, stall_lim=0, no commits -> finish when cycles=100 plus 1, cause=2; with timeout_lim=0 no finish in 1000 cycles.
REQ-039 stall_lim=8: commits, idle 7, one commit, then idle -> no finish at first gap; cause=3 after 8 idle cycles.
REQ-040 LOOP_W=4, single channel commits PC 0x100 every cycle, loop_en=1 -> cause=4 the cycle after the 16th commit; loop_en=0 -> no finish.
REQ-041 DRAIN_CYC=5, errcode=3 at cycle 10, halt at cycle 12, errcode=7 at cycle 13 -> finish at cycle 16, cause=5, err_latched=3.
REQ-042 halt and errcode in the same cycle -> DRAIN, cause=5; rst during DRAIN -> no finish, all outputs 0, last_pc=0x60.
